// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: requester ids, the request
// bundle seen by the picker/mux, and the data-phase bookkeeping record.
package mem_arb_pkg;

    // Default geometry; struct field widths below follow these values.
    localparam int MEM_RPORTS = 2;
    localparam int MEM_AW     = 8;
    localparam int MEM_DW     = 16;
    localparam int MEM_NREQ   = MEM_RPORTS + 2;
    localparam int MEM_IDW    = $clog2(MEM_NREQ);

    // Requester id encoding: fetch port k uses id ID_IF0 + k.
    localparam logic [MEM_IDW-1:0] ID_FP  = MEM_IDW'(0);
    localparam logic [MEM_IDW-1:0] ID_LSU = MEM_IDW'(1);
    localparam logic [MEM_IDW-1:0] ID_IF0 = MEM_IDW'(2);

    // One requester's issue-side view.
    typedef struct packed {
        logic              val;
        logic              wen;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

    // What was issued last cycle, needed to route the RAM response.
    typedef struct packed {
        logic               val;
        logic [MEM_IDW-1:0] id;
        logic [MEM_AW-1:0]  addr;
        logic               wen;
    } dphase_t;

    // True for ids that belong to an instruction-fetch port.
    function automatic logic is_fetch_id(input logic [MEM_IDW-1:0] id);
        return id >= ID_IF0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: FP, then boosted fetch, then LSU, then
// fetch (lowest port first). The requester still in its data phase is masked.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = MEM_NREQ,
    parameter int IDW  = MEM_IDW
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            excl_val_i,
    input  logic [IDW-1:0]  excl_id_i,
    input  logic            boost_i,
    output logic [IDW-1:0]  id_o,
    output logic            val_o
);

    localparam int I_FP  = int'(ID_FP);
    localparam int I_LSU = int'(ID_LSU);
    localparam int I_IF0 = int'(ID_IF0);

    logic [NREQ-1:0] w_elig;
    logic [IDW-1:0]  w_if_id;
    logic            w_if_any;

    // A requester may not be issued again while its previous access is in the data phase.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
        assign w_elig[gi] = req_i[gi] & ~(excl_val_i && (excl_id_i == IDW'(gi)));
    end

    // Lowest-index eligible fetch port (scan high to low so the lowest wins).
    always_comb begin
        w_if_id  = '0;
        w_if_any = 1'b0;
        for (int k = NREQ - 1; k >= I_IF0; k--) begin
            if (w_elig[k]) begin
                w_if_id  = IDW'(k);
                w_if_any = 1'b1;
            end
        end
    end

    // Fixed priority with the fetch boost slotted between FP and LSU.
    always_comb begin
        id_o  = '0;
        val_o = 1'b0;
        if (w_elig[I_FP]) begin
            id_o  = IDW'(I_FP);
            val_o = 1'b1;
        end else if (boost_i && w_if_any) begin
            id_o  = w_if_id;
            val_o = 1'b1;
        end else if (w_elig[I_LSU]) begin
            id_o  = IDW'(I_LSU);
            val_o = 1'b1;
        end else if (w_if_any) begin
            id_o  = w_if_id;
            val_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between the front-panel loader, the
// LSU and N_RPORTS fetch ports. One access issued per cycle; the response is
// returned to the owner in the following cycle if it still presents the same
// request. AW/DW/N_RPORTS are expected to stay at the package defaults, since
// the request/data-phase records take their field widths from the package.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_RPORTS = MEM_RPORTS,
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic                              fp_val_i,
    input  logic                              fp_wen_i,
    input  logic [AW-1:0]                     fp_addr_i,
    input  logic [DW-1:0]                     fp_wdata_i,
    output logic                              fp_rdy_o,
    output logic [DW-1:0]                     fp_rdata_o,
    input  logic                              lsu_val_i,
    input  logic                              lsu_wen_i,
    input  logic [AW-1:0]                     lsu_addr_i,
    input  logic [DW-1:0]                     lsu_wdata_i,
    output logic                              lsu_rdy_o,
    output logic [DW-1:0]                     lsu_rdata_o,
    input  logic [N_RPORTS-1:0]               if_val_i,
    input  logic [N_RPORTS*AW-1:0]            if_addr_i,
    output logic [N_RPORTS-1:0]               if_rdy_o,
    output logic [DW-1:0]                     if_rdata_o,
    output logic                              ram_en_o,
    output logic                              ram_wen_o,
    output logic [AW-1:0]                     ram_addr_o,
    output logic [DW-1:0]                     ram_wdata_o,
    input  logic [DW-1:0]                     ram_rdata_i,
    output logic [$clog2(N_RPORTS+2)-1:0]     grant_id_o,
    output logic                              grant_val_o
);

    localparam int NREQ = N_RPORTS + 2;
    localparam int IDW  = $clog2(N_RPORTS + 2);
    localparam int WCW  = $clog2(MAX_WAIT + 1);

    mem_req_t        w_req [NREQ];
    logic [NREQ-1:0] w_req_val;
    logic [NREQ-1:0] w_rdy;
    logic [IDW-1:0]  w_pick_id;
    logic            w_pick_val;
    logic            w_issue;
    mem_req_t        w_win;
    logic            w_boost;
    logic            w_if_pend;
    logic            w_if_grant;
    logic            w_other_win;
    logic [DW-1:0]   w_rd_data;

    dphase_t         r_dphase;
    logic [WCW-1:0]  r_wait;

    // Gather every requester into a uniform record indexed by requester id.
    assign w_req[int'(ID_FP)]  = '{val: fp_val_i,  wen: fp_wen_i,  addr: fp_addr_i,  wdata: fp_wdata_i};
    assign w_req[int'(ID_LSU)] = '{val: lsu_val_i, wen: lsu_wen_i, addr: lsu_addr_i, wdata: lsu_wdata_i};
    for (genvar gi = 0; gi < N_RPORTS; gi++) begin : g_if_req
        assign w_req[int'(ID_IF0) + gi] = '{val: if_val_i[gi], wen: 1'b0,
                                            addr: if_addr_i[gi*AW +: AW], wdata: '0};
    end
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_val
        assign w_req_val[gi] = w_req[gi].val;
    end

    assign w_boost = (r_wait == WCW'(MAX_WAIT));

    mem_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i      (w_req_val),
        .excl_val_i (r_dphase.val),
        .excl_id_i  (r_dphase.id),
        .boost_i    (w_boost),
        .id_o       (w_pick_id),
        .val_o      (w_pick_val)
    );

    // Nothing reaches the RAM while reset is held, so no stray write can land.
    assign w_issue = w_pick_val & arst_ni;
    assign w_win   = w_req[w_pick_id];

    assign ram_en_o    = w_issue;
    assign ram_wen_o   = w_issue & w_win.wen;
    assign ram_addr_o  = w_issue ? w_win.addr : '0;
    assign ram_wdata_o = (w_issue && w_win.wen) ? w_win.wdata : '0;
    assign grant_val_o = w_issue;
    assign grant_id_o  = w_issue ? w_pick_id : '0;

    // Remember what went to the RAM so the response can be routed next cycle.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_dphase <= '0;
        end else if (w_issue) begin
            r_dphase <= '{val: 1'b1, id: w_pick_id, addr: w_win.addr, wen: w_win.wen};
        end else begin
            r_dphase <= '0;
        end
    end

    assign w_if_pend   = |if_val_i;
    assign w_if_grant  = w_issue && is_fetch_id(w_pick_id);
    assign w_other_win = w_issue && !w_if_grant;

    // Count cycles a pending fetch loses to FP/LSU; saturates to raise the boost.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wait <= '0;
        end else if (!w_if_pend || w_if_grant) begin
            r_wait <= '0;
        end else if (w_other_win && !w_boost) begin
            r_wait <= r_wait + WCW'(1);
        end
    end

    // Response goes only to the owner that still presents the same request.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rdy
        assign w_rdy[gi] = r_dphase.val && (r_dphase.id == IDW'(gi)) &&
                           w_req[gi].val && (w_req[gi].addr == r_dphase.addr);
    end

    assign w_rd_data = r_dphase.wen ? '0 : ram_rdata_i;

    assign fp_rdy_o    = w_rdy[int'(ID_FP)];
    assign fp_rdata_o  = fp_rdy_o ? w_rd_data : '0;
    assign lsu_rdy_o   = w_rdy[int'(ID_LSU)];
    assign lsu_rdata_o = lsu_rdy_o ? w_rd_data : '0;
    assign if_rdy_o    = w_rdy[NREQ-1:int'(ID_IF0)];
    assign if_rdata_o  = (|if_rdy_o) ? w_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first synchronous RAM model.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 2;

    logic              clk_i = 1'b0;
    logic              arst_ni;
    logic              fp_val_i, fp_wen_i;
    logic [AW-1:0]     fp_addr_i;
    logic [DW-1:0]     fp_wdata_i;
    logic              fp_rdy_o;
    logic [DW-1:0]     fp_rdata_o;
    logic              lsu_val_i, lsu_wen_i;
    logic [AW-1:0]     lsu_addr_i;
    logic [DW-1:0]     lsu_wdata_i;
    logic              lsu_rdy_o;
    logic [DW-1:0]     lsu_rdata_o;
    logic [NR-1:0]     if_val_i;
    logic [NR*AW-1:0]  if_addr_i;
    logic [NR-1:0]     if_rdy_o;
    logic [DW-1:0]     if_rdata_o;
    logic              ram_en_o, ram_wen_o;
    logic [AW-1:0]     ram_addr_o;
    logic [DW-1:0]     ram_wdata_o;
    logic [DW-1:0]     ram_rdata;
    logic [1:0]        grant_id_o;
    logic              grant_val_o;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.N_RPORTS(NR), .AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .fp_val_i    (fp_val_i),
        .fp_wen_i    (fp_wen_i),
        .fp_addr_i   (fp_addr_i),
        .fp_wdata_i  (fp_wdata_i),
        .fp_rdy_o    (fp_rdy_o),
        .fp_rdata_o  (fp_rdata_o),
        .lsu_val_i   (lsu_val_i),
        .lsu_wen_i   (lsu_wen_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_rdy_o   (lsu_rdy_o),
        .lsu_rdata_o (lsu_rdata_o),
        .if_val_i    (if_val_i),
        .if_addr_i   (if_addr_i),
        .if_rdy_o    (if_rdy_o),
        .if_rdata_o  (if_rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_wen_o   (ram_wen_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata),
        .grant_id_o  (grant_id_o),
        .grant_val_o (grant_val_o)
    );

    always #5 clk_i = ~clk_i;

    // Write-first single-port RAM: read data appears the cycle after the access.
    logic [DW-1:0] mem [256];
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_wen_o) begin
                mem[ram_addr_o] <= ram_wdata_o;
                ram_rdata       <= ram_wdata_o;
            end else begin
                ram_rdata <= mem[ram_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Sample point: falling edge, away from the active edge.
    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic set_if(input int k, input logic v, input logic [AW-1:0] a);
        if_val_i[k]         = v;
        if_addr_i[k*AW +: AW] = a;
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [1:0] id);
        check({tag, ".gval"}, grant_val_o, v);
        check({tag, ".gid"},  grant_id_o,  v ? id : 2'd0);
        check({tag, ".en"},   ram_en_o,    v);
    endtask

    // Preload a word through the front-panel port (two-cycle write handshake).
    task automatic fp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        fp_val_i = 1'b1; fp_wen_i = 1'b1; fp_addr_i = a; fp_wdata_i = d;
        settle();
        chk_grant("fpw.issue", 1'b1, 2'd0);
        check("fpw.wen", ram_wen_o, 1'b1);
        check("fpw.wdata", ram_wdata_o, d);
        step();
        settle();
        check("fpw.rdy", fp_rdy_o, 1'b1);
        check("fpw.rdata0", fp_rdata_o, 16'h0);
        step();
        fp_val_i = 1'b0; fp_wen_i = 1'b0;
        $display("txn fp_write addr=%02h data=%04h", a, d);
    endtask

    initial begin
        arst_ni = 1'b0;
        fp_val_i = 0; fp_wen_i = 0; fp_addr_i = '0; fp_wdata_i = '0;
        lsu_val_i = 0; lsu_wen_i = 0; lsu_addr_i = '0; lsu_wdata_i = '0;
        if_val_i = '0; if_addr_i = '0;

        // Reset state, with a request held to show nothing is issued in reset.
        lsu_val_i = 1'b1; lsu_addr_i = 8'h20;
        step();
        settle();
        chk_grant("rst", 1'b0, 2'd0);
        check("rst.wen", ram_wen_o, 1'b0);
        check("rst.addr", ram_addr_o, 8'h00);
        check("rst.fprdy", fp_rdy_o, 1'b0);
        check("rst.lsurdy", lsu_rdy_o, 1'b0);
        check("rst.ifrdy", if_rdy_o, 2'b00);
        check("rst.lsudata", lsu_rdata_o, 16'h0);
        lsu_val_i = 1'b0;
        step();
        arst_ni = 1'b1;
        step();
        $display("txn reset");

        fp_write(8'h20, 16'h1234);
        fp_write(8'h40, 16'h0A0A);
        fp_write(8'h11, 16'h5A5A);
        fp_write(8'h12, 16'h7777);

        // Single LSU read.
        lsu_val_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 8'h20;
        settle();
        chk_grant("t1.issue", 1'b1, 2'd1);
        check("t1.addr", ram_addr_o, 8'h20);
        check("t1.wen", ram_wen_o, 1'b0);
        check("t1.rdy_early", lsu_rdy_o, 1'b0);
        step();
        settle();
        check("t1.rdy", lsu_rdy_o, 1'b1);
        check("t1.data", lsu_rdata_o, 16'h1234);
        check("t1.fprdy", fp_rdy_o, 1'b0);
        check("t1.ifrdy", if_rdy_o, 2'b00);
        chk_grant("t1.excl", 1'b0, 2'd0);
        step();
        lsu_val_i = 1'b0;
        settle();
        check("t1.rdy_once", lsu_rdy_o, 1'b0);
        check("t1.data_idle", lsu_rdata_o, 16'h0);
        step();
        $display("txn lsu_read 20");

        // LSU write then fetch read of the same address on the next issue cycle.
        lsu_val_i = 1'b1; lsu_wen_i = 1'b1; lsu_addr_i = 8'h30; lsu_wdata_i = 16'hBEEF;
        settle();
        chk_grant("t2.wr", 1'b1, 2'd1);
        check("t2.wen", ram_wen_o, 1'b1);
        check("t2.wdata", ram_wdata_o, 16'hBEEF);
        step();
        set_if(0, 1'b1, 8'h30);
        settle();
        check("t2.lsurdy", lsu_rdy_o, 1'b1);
        check("t2.lsudata", lsu_rdata_o, 16'h0);
        chk_grant("t2.if0", 1'b1, 2'd2);
        check("t2.if0addr", ram_addr_o, 8'h30);
        step();
        lsu_val_i = 1'b0; lsu_wen_i = 1'b0;
        settle();
        check("t2.ifrdy", if_rdy_o, 2'b01);
        check("t2.ifdata", if_rdata_o, 16'hBEEF);
        check("t2.lsurdy_off", lsu_rdy_o, 1'b0);
        step();
        set_if(0, 1'b0, 8'h00);
        $display("txn raw lsu_write 30 / if0_read 30");

        // All four requesters at once; each drops val after its response.
        fp_val_i = 1'b1; fp_addr_i = 8'h20;
        lsu_val_i = 1'b1; lsu_addr_i = 8'h40;
        set_if(0, 1'b1, 8'h30);
        set_if(1, 1'b1, 8'h11);
        settle();
        chk_grant("t3.c0", 1'b1, 2'd0);
        step();
        settle();
        check("t3.fprdy", fp_rdy_o, 1'b1);
        check("t3.fpdata", fp_rdata_o, 16'h1234);
        check("t3.c1.lsurdy", lsu_rdy_o, 1'b0);
        chk_grant("t3.c1", 1'b1, 2'd1);
        step();
        fp_val_i = 1'b0;
        settle();
        check("t3.lsurdy", lsu_rdy_o, 1'b1);
        check("t3.lsudata", lsu_rdata_o, 16'h0A0A);
        check("t3.c2.fprdy", fp_rdy_o, 1'b0);
        chk_grant("t3.c2", 1'b1, 2'd2);
        step();
        lsu_val_i = 1'b0;
        settle();
        check("t3.if0rdy", if_rdy_o, 2'b01);
        check("t3.if0data", if_rdata_o, 16'hBEEF);
        chk_grant("t3.c3", 1'b1, 2'd3);
        step();
        set_if(0, 1'b0, 8'h00);
        settle();
        check("t3.if1rdy", if_rdy_o, 2'b10);
        check("t3.if1data", if_rdata_o, 16'h5A5A);
        chk_grant("t3.c4", 1'b0, 2'd0);
        step();
        set_if(1, 1'b0, 8'h00);
        step();
        $display("txn four-way order fp,lsu,if0,if1");

        // Starvation boost. LSU alone cannot starve fetch (it is masked every
        // other cycle), so FP and LSU together keep if0 losing until boosted.
        fp_val_i = 1'b1; fp_addr_i = 8'h20;
        lsu_val_i = 1'b1; lsu_addr_i = 8'h40;
        set_if(0, 1'b1, 8'h30);
        settle(); chk_grant("t4.c0", 1'b1, 2'd0); step();
        settle(); chk_grant("t4.c1", 1'b1, 2'd1); check("t4.c1.fprdy", fp_rdy_o, 1'b1); step();
        settle(); chk_grant("t4.c2", 1'b1, 2'd0); check("t4.c2.lsurdy", lsu_rdy_o, 1'b1); step();
        settle(); chk_grant("t4.c3", 1'b1, 2'd1); step();
        settle(); chk_grant("t4.c4", 1'b1, 2'd0); step();
        settle(); chk_grant("t4.c5boost", 1'b1, 2'd2); check("t4.c5.fprdy", fp_rdy_o, 1'b1); step();
        settle(); chk_grant("t4.c6", 1'b1, 2'd0);
        check("t4.c6.ifrdy", if_rdy_o, 2'b01); check("t4.c6.ifdata", if_rdata_o, 16'hBEEF); step();
        settle(); chk_grant("t4.c7clear", 1'b1, 2'd1); step();
        fp_val_i = 1'b0; lsu_val_i = 1'b0; set_if(0, 1'b0, 8'h00);
        settle();
        check("t4.c8.lsuwithdrawn", lsu_rdy_o, 1'b0);
        chk_grant("t4.c8", 1'b0, 2'd0);
        step();
        $display("txn fetch boost after 4 losses");

        // Withdrawn fetch: no response, and the next arbitration proceeds normally.
        set_if(1, 1'b1, 8'h11);
        settle(); chk_grant("t5.c0", 1'b1, 2'd3); step();
        set_if(1, 1'b0, 8'h00);
        set_if(0, 1'b1, 8'h30);
        settle();
        check("t5.drop.rdy", if_rdy_o, 2'b00);
        check("t5.drop.data", if_rdata_o, 16'h0);
        chk_grant("t5.c1", 1'b1, 2'd2);
        step();
        settle();
        check("t5.if0rdy", if_rdy_o, 2'b01);
        check("t5.if0data", if_rdata_o, 16'hBEEF);
        step();
        set_if(0, 1'b0, 8'h00);
        // Owner keeps val but changes address: result discarded.
        set_if(1, 1'b1, 8'h11);
        settle(); chk_grant("t5.c3", 1'b1, 2'd3); step();
        set_if(1, 1'b1, 8'h12);
        settle();
        check("t5.addrchg.rdy", if_rdy_o, 2'b00);
        chk_grant("t5.c4", 1'b0, 2'd0);
        step();
        settle(); chk_grant("t5.c5", 1'b1, 2'd3); check("t5.c5.addr", ram_addr_o, 8'h12); step();
        settle();
        check("t5.if1rdy", if_rdy_o, 2'b10);
        check("t5.if1data", if_rdata_o, 16'h7777);
        step();
        set_if(1, 1'b0, 8'h00);
        step();
        $display("txn fetch withdraw / address change");

        // Reset during an LSU read data cycle.
        lsu_val_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 8'h20;
        settle(); chk_grant("t6.issue", 1'b1, 2'd1); step();
        arst_ni = 1'b0;
        settle();
        check("t6.rdy", lsu_rdy_o, 1'b0);
        check("t6.data", lsu_rdata_o, 16'h0);
        check("t6.addr", ram_addr_o, 8'h00);
        chk_grant("t6.inrst", 1'b0, 2'd0);
        step();
        arst_ni = 1'b1;
        settle();
        chk_grant("t6.reissue", 1'b1, 2'd1);
        check("t6.rdy_post", lsu_rdy_o, 1'b0);
        step();
        settle();
        check("t6.rdy_lat", lsu_rdy_o, 1'b1);
        check("t6.data_lat", lsu_rdata_o, 16'h1234);
        step();
        lsu_val_i = 1'b0;
        step();
        $display("txn reset during lsu data phase");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
